// File: rtl/noc_pkg.sv
// Shared sizing, VC state encoding and index types for the output-port scheduler.
package noc_pkg;

  localparam int PN  = 5;
  localparam int VCN = 2;
  localparam int CD  = 4;
  localparam int CW  = $clog2(CD + 1);

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } vc_state_e;

  typedef logic [clog2_min1(PN)-1:0] port_idx_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin pick: first eligible index strictly after ptr, wrapping; one-hot or zero.
module rr_arb
  import noc_pkg::*;
#(
  parameter int N  = 10,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && elig[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_sched.sv
// Output-port scheduler: per-VC ownership and credits, round-robin flit grant.
//   state | meaning
//   FREE  | VC has no packet in flight; only head flits may claim it
//   BUSY  | VC owned by own_q[v]; only that port's body/tail flits proceed
module out_sched
  import noc_pkg::*;
#(
  parameter int PN  = noc_pkg::PN,
  parameter int VCN = noc_pkg::VCN,
  parameter int CD  = noc_pkg::CD,
  parameter int CW  = $clog2(CD + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PN-1:0][VCN-1:0]   req,
  input  logic [PN-1:0][VCN-1:0]   hof,
  input  logic [PN-1:0][VCN-1:0]   eof,
  output logic [PN-1:0][VCN-1:0]   gnt,
  input  logic [VCN-1:0]           cr_ret,
  output logic [VCN-1:0][CW-1:0]   crd,
  output logic [VCN-1:0]           vc_busy,
  output logic                     err
);

  localparam int N  = PN * VCN;
  localparam int PW = clog2_min1(N);

  vc_state_e              state_q [VCN];
  vc_state_e              state_d [VCN];
  port_idx_t              own_q   [VCN];
  port_idx_t              own_d   [VCN];
  logic [VCN-1:0][CW-1:0] crd_q, crd_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   err_q, err_d;

  logic [N-1:0]           elig;
  logic [N-1:0]           gnt_flat;
  logic [VCN-1:0]         xfer;

  rr_arb #(.N(N), .PW(PW)) u_arb (
    .elig (elig),
    .ptr  (ptr_q),
    .gnt  (gnt_flat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VCN; v++) begin
        state_q[v] <= FREE;
        own_q[v]   <= '0;
      end
      crd_q <= {VCN{CW'(CD)}};
      ptr_q <= PW'(N - 1);
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      crd_q   <= crd_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    crd_d   = crd_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    xfer    = '0;
    for (int p = 0; p < PN; p++) begin
      for (int v = 0; v < VCN; v++) begin
        if (gnt_flat[p*VCN+v]) begin
          ptr_d   = PW'(p*VCN + v);
          xfer[v] = 1'b1;
          if (hof[p][v] && !eof[p][v]) begin
            state_d[v] = BUSY;
            own_d[v]   = port_idx_t'(p);
          end else if (eof[p][v]) begin
            state_d[v] = FREE;
          end
        end
      end
    end
    // A return coinciding with a transfer cancels out; a return into a full VC is a protocol error.
    for (int v = 0; v < VCN; v++) begin
      if (xfer[v] && !cr_ret[v]) begin
        crd_d[v] = crd_q[v] - CW'(1);
      end else if (!xfer[v] && cr_ret[v]) begin
        if (crd_q[v] == CW'(CD)) err_d = 1'b1;
        else                     crd_d[v] = crd_q[v] + CW'(1);
      end
    end
  end

  always_comb begin
    elig = '0;
    for (int p = 0; p < PN; p++) begin
      for (int v = 0; v < VCN; v++) begin
        elig[p*VCN+v] = !rst && req[p][v] && (crd_q[v] != '0) &&
                        ((state_q[v] == FREE && hof[p][v]) ||
                         (state_q[v] == BUSY && own_q[v] == port_idx_t'(p) && !hof[p][v]));
      end
    end
  end

  always_comb begin
    for (int v = 0; v < VCN; v++) vc_busy[v] = (state_q[v] == BUSY);
  end

  assign gnt = gnt_flat;
  assign crd = crd_q;
  assign err = err_q;

endmodule

// File: tb/tb_out_sched.sv
// Directed bench for out_sched with default sizing (5 ports, 2 VCs, depth 4).
module tb_out_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0][1:0]  req, hof, eof, gnt;
  logic [1:0]       cr_ret;
  logic [1:0][2:0]  crd;
  logic [1:0]       vc_busy;
  logic             err;
  int               n_cmp = 0;
  int               n_bad = 0;

  out_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .hof     (hof),
    .eof     (eof),
    .gnt     (gnt),
    .cr_ret  (cr_ret),
    .crd     (crd),
    .vc_busy (vc_busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req = '0; hof = '0; eof = '0; cr_ret = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; hof = '1; eof = '1; cr_ret = '0;
    tick();
    n_cmp++; if (gnt !== 10'h000) begin n_bad++; $display("FAIL rst_gnt got %h want %h", gnt, 10'h000); end
    n_cmp++; if (crd !== 6'b100_100) begin n_bad++; $display("FAIL rst_crd got %b want %b", crd, 6'b100_100); end
    n_cmp++; if (vc_busy !== 2'b00) begin n_bad++; $display("FAIL rst_busy got %b want 00", vc_busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
    clr(); rst = 1'b0;
    hof = '1; eof = '1;
    #1;
    n_cmp++; if (gnt !== 10'h000) begin n_bad++; $display("FAIL hof_no_req got %h want %h", gnt, 10'h000); end
    clr();
  endtask

  task automatic test_single();
    req[0][0] = 1'b1; hof[0][0] = 1'b1; eof[0][0] = 1'b1;
    #1;
    n_cmp++; if (gnt !== 10'h001) begin n_bad++; $display("FAIL single_gnt got %h want %h", gnt, 10'h001); end
    tick();
    n_cmp++; if (crd[0] !== 3'd3) begin n_bad++; $display("FAIL single_crd got %0d want 3", crd[0]); end
    n_cmp++; if (vc_busy[0] !== 1'b0) begin n_bad++; $display("FAIL single_busy got %b want 0", vc_busy[0]); end
    clr(); cr_ret[0] = 1'b1;
    tick();
    clr();
    n_cmp++; if (crd[0] !== 3'd4) begin n_bad++; $display("FAIL single_ret got %0d want 4", crd[0]); end
  endtask

  task automatic test_block();
    req[1][1] = 1'b1; hof[1][1] = 1'b1;
    req[2][1] = 1'b1; hof[2][1] = 1'b1;
    #1;
    n_cmp++; if (gnt !== 10'h008) begin n_bad++; $display("FAIL blk_head got %h want %h", gnt, 10'h008); end
    tick();
    n_cmp++; if (vc_busy[1] !== 1'b1 || crd[1] !== 3'd3) begin n_bad++; $display("FAIL blk_head_st got busy %b crd %0d want 1 3", vc_busy[1], crd[1]); end
    hof[1][1] = 1'b0;
    #1;
    n_cmp++; if (gnt !== 10'h008) begin n_bad++; $display("FAIL blk_body got %h want %h", gnt, 10'h008); end
    tick();
    n_cmp++; if (vc_busy[1] !== 1'b1 || crd[1] !== 3'd2) begin n_bad++; $display("FAIL blk_body_st got busy %b crd %0d want 1 2", vc_busy[1], crd[1]); end
    eof[1][1] = 1'b1;
    #1;
    n_cmp++; if (gnt !== 10'h008) begin n_bad++; $display("FAIL blk_tail got %h want %h", gnt, 10'h008); end
    tick();
    n_cmp++; if (vc_busy[1] !== 1'b0 || crd[1] !== 3'd1) begin n_bad++; $display("FAIL blk_tail_st got busy %b crd %0d want 0 1", vc_busy[1], crd[1]); end
    req[1][1] = 1'b0; eof[1][1] = 1'b0;
    #1;
    n_cmp++; if (gnt !== 10'h020) begin n_bad++; $display("FAIL blk_second got %h want %h", gnt, 10'h020); end
    tick();
    n_cmp++; if (vc_busy[1] !== 1'b1 || crd[1] !== 3'd0) begin n_bad++; $display("FAIL blk_second_st got busy %b crd %0d want 1 0", vc_busy[1], crd[1]); end
    hof[2][1] = 1'b0; eof[2][1] = 1'b1; cr_ret[1] = 1'b1;
    #1;
    n_cmp++; if (gnt !== 10'h000) begin n_bad++; $display("FAIL blk_nocrd got %h want %h", gnt, 10'h000); end
    tick();
    n_cmp++; if (crd[1] !== 3'd1) begin n_bad++; $display("FAIL blk_ret got %0d want 1", crd[1]); end
    #1;
    n_cmp++; if (gnt !== 10'h020) begin n_bad++; $display("FAIL blk_tail2 got %h want %h", gnt, 10'h020); end
    tick();
    n_cmp++; if (crd[1] !== 3'd1 || vc_busy[1] !== 1'b0) begin n_bad++; $display("FAIL blk_xfer_ret got crd %0d busy %b want 1 0", crd[1], vc_busy[1]); end
    clr(); cr_ret[1] = 1'b1;
    tick(); tick(); tick();
    clr();
    n_cmp++; if (crd[1] !== 3'd4 || err !== 1'b0) begin n_bad++; $display("FAIL blk_refill got crd %0d err %b want 4 0", crd[1], err); end
  endtask

  task automatic test_rotate();
    logic [9:0] exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      req[p][0] = 1'b1; hof[p][0] = 1'b1; eof[p][0] = 1'b1;
    end
    cr_ret[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp = 10'b1 << (2 * (k % 5));
      #1;
      n_cmp++; if (gnt !== exp) begin n_bad++; $display("FAIL rot_gnt[%0d] got %h want %h", k, gnt, exp); end
      tick();
      n_cmp++; if (crd[0] !== 3'd4) begin n_bad++; $display("FAIL rot_crd[%0d] got %0d want 4", k, crd[0]); end
    end
    clr();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rot_err got %b want 0", err); end
  endtask

  task automatic test_credit();
    req[0][0] = 1'b1; hof[0][0] = 1'b1; eof[0][0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (gnt !== 10'h001) begin n_bad++; $display("FAIL crd_gnt[%0d] got %h want %h", k, gnt, 10'h001); end
      tick();
      n_cmp++; if (crd[0] !== 3'(3 - k)) begin n_bad++; $display("FAIL crd_val[%0d] got %0d want %0d", k, crd[0], 3 - k); end
    end
    #1;
    n_cmp++; if (gnt !== 10'h000) begin n_bad++; $display("FAIL crd_empty got %h want %h", gnt, 10'h000); end
    cr_ret[0] = 1'b1;
    tick();
    cr_ret[0] = 1'b0;
    n_cmp++; if (crd[0] !== 3'd1) begin n_bad++; $display("FAIL crd_one got %0d want 1", crd[0]); end
    #1;
    n_cmp++; if (gnt !== 10'h001) begin n_bad++; $display("FAIL crd_regnt got %h want %h", gnt, 10'h001); end
    tick();
    n_cmp++; if (crd[0] !== 3'd0) begin n_bad++; $display("FAIL crd_zero got %0d want 0", crd[0]); end
    clr(); cr_ret[0] = 1'b1;
    tick(); tick(); tick(); tick();
    clr();
    n_cmp++; if (crd[0] !== 3'd4) begin n_bad++; $display("FAIL crd_refill got %0d want 4", crd[0]); end
  endtask

  task automatic test_overflow();
    cr_ret[1] = 1'b1;
    tick();
    clr();
    n_cmp++; if (err !== 1'b1 || crd[1] !== 3'd4) begin n_bad++; $display("FAIL ovf got err %b crd %0d want 1 4", err, crd[1]); end
    tick(); tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    req[0][0] = 1'b1; hof[0][0] = 1'b1;
    #1;
    n_cmp++; if (gnt !== 10'h001) begin n_bad++; $display("FAIL mid_head got %h want %h", gnt, 10'h001); end
    tick();
    n_cmp++; if (vc_busy[0] !== 1'b1 || crd[0] !== 3'd3) begin n_bad++; $display("FAIL mid_head_st got busy %b crd %0d want 1 3", vc_busy[0], crd[0]); end
    hof[0][0] = 1'b0;
    tick();
    n_cmp++; if (vc_busy[0] !== 1'b1 || crd[0] !== 3'd2) begin n_bad++; $display("FAIL mid_body_st got busy %b crd %0d want 1 2", vc_busy[0], crd[0]); end
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== 10'h000) begin n_bad++; $display("FAIL mid_rst_gnt got %h want %h", gnt, 10'h000); end
    n_cmp++; if (crd !== 6'b100_100 || vc_busy !== 2'b00 || err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_st got crd %b busy %b err %b want 100100 00 0", crd, vc_busy, err); end
    tick();
    rst = 1'b0;
    clr();
    req[3][0] = 1'b1; hof[3][0] = 1'b1;
    #1;
    n_cmp++; if (gnt !== 10'h040) begin n_bad++; $display("FAIL mid_new_head got %h want %h", gnt, 10'h040); end
    tick();
    clr();
    n_cmp++; if (vc_busy[0] !== 1'b1 || crd[0] !== 3'd3) begin n_bad++; $display("FAIL mid_new_st got busy %b crd %0d want 1 3", vc_busy[0], crd[0]); end
  endtask

  initial begin
    clr();
    test_reset();
    test_single();
    test_block();
    test_rotate();
    test_credit();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
